// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte-lane steering for stores, sign/zero extension for loads.
// Define LSU_MISALIGNED_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [3:0]  i_in_op,
  input  logic [31:0] i_in_addr,
  input  logic [31:0] i_in_wdata,
  input  logic [4:0]  i_in_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_out_valid,
  output logic [4:0]  o_out_rd,
  output logic [31:0] o_out_res,
  output logic        o_out_err,
  output logic        o_out_misaligned
);

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      r_state, w_state_d;
  logic        r_store, r_unsigned;
  logic [1:0]  r_size, r_lane;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;
  logic        r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [4:0]  r_out_rd, w_rd_d;
  logic [31:0] r_out_res, w_res_d;
  logic        r_out_err, w_err_d;
  logic        r_out_mis, w_mis_d;

  logic        w_accept, w_nop, w_misaligned, w_issue;
  logic [1:0]  w_lane;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata, w_shift, w_load;

  assign w_accept = i_in_valid && (r_state == StIdle);
  assign w_nop    = (i_in_op == 4'hF);

`ifdef LSU_MISALIGNED_TRAP_EN
  assign w_misaligned = ((i_in_op[1:0] == 2'd1) && i_in_addr[0]) ||
                        (i_in_op[1] && (i_in_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_issue = w_accept && !w_nop && !w_misaligned;

  // Size code 3 falls into the word arm everywhere.
  always_comb begin
    w_lane  = 2'b00;
    w_strb  = 4'b1111;
    w_wdata = i_in_wdata;
    unique case (i_in_op[1:0])
      2'd0: begin
        w_lane  = i_in_addr[1:0];
        w_strb  = 4'b0001 << i_in_addr[1:0];
        w_wdata = {4{i_in_wdata[7:0]}};
      end
      2'd1: begin
        w_lane  = {i_in_addr[1], 1'b0};
        w_strb  = i_in_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = i_mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load = i_mem_rdata;
    unique case (r_size)
      2'd0:    w_load = {{24{~r_unsigned & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_res_d   = r_out_res;
    w_err_d   = r_out_err;
    w_mis_d   = r_out_mis;
    w_rd_d    = r_out_rd;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_nop || w_misaligned) begin
            w_state_d = StResp;
            w_res_d   = 32'd0;
            w_err_d   = 1'b0;
            w_mis_d   = !w_nop;
            w_rd_d    = (!w_nop && i_in_op[3]) ? 5'd0 : i_in_rd;
          end else begin
            w_state_d = StReq;
          end
        end
      end
      StReq: begin
        if (i_mem_gnt) begin
          if (r_store) begin
            w_state_d = StResp;
            w_res_d   = 32'd0;
            w_err_d   = 1'b0;
            w_mis_d   = 1'b0;
            w_rd_d    = 5'd0;
          end else begin
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (i_mem_rvalid) begin
          w_state_d = StResp;
          w_res_d   = w_load;
          w_err_d   = 1'b0;
          w_mis_d   = 1'b0;
          w_rd_d    = r_rd;
        end else if (r_cnt == WaitLast) begin
          w_state_d = StResp;
          w_res_d   = 32'd0;
          w_err_d   = 1'b1;
          w_mis_d   = 1'b0;
          w_rd_d    = r_rd;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_store     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'd0;
      r_lane      <= 2'd0;
      r_rd        <= 5'd0;
      r_cnt       <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_out_rd    <= 5'd0;
      r_out_res   <= 32'd0;
      r_out_err   <= 1'b0;
      r_out_mis   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_out_rd  <= w_rd_d;
      r_out_res <= w_res_d;
      r_out_err <= w_err_d;
      r_out_mis <= w_mis_d;
      if (w_issue) begin
        r_store     <= i_in_op[3];
        r_unsigned  <= i_in_op[2];
        r_size      <= i_in_op[1:0];
        r_lane      <= w_lane;
        r_rd        <= i_in_rd;
        r_mem_we    <= i_in_op[3];
        r_mem_addr  <= {i_in_addr[31:2], 2'b00};
        r_mem_wstrb <= w_strb;
        r_mem_wdata <= w_wdata;
      end
      if (r_state == StReq) begin
        r_cnt <= 8'd0;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_in_ready       = (r_state == StIdle);
  assign o_mem_req        = (r_state == StReq);
  assign o_mem_we         = r_mem_we;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wstrb      = r_mem_wstrb;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_out_valid      = (r_state == StResp);
  assign o_out_rd         = r_out_rd;
  assign o_out_res        = r_out_res;
  assign o_out_err        = r_out_err;
  assign o_out_misaligned = r_out_mis;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random transactions against a byte-level model.
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'h0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid, out_err, out_mis;
  logic [4:0]  out_rd;
  logic [31:0] out_res;

  int vecs = 0;
  int errs = 0;
  logic [31:0] prev_res = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(in_op), .i_in_addr(in_addr),
    .i_in_wdata(in_wdata), .i_in_rd(in_rd),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wstrb(mem_wstrb),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata),
    .o_out_valid(out_valid), .o_out_rd(out_rd), .o_out_res(out_res), .o_out_err(out_err),
    .o_out_misaligned(out_mis)
  );

  // One complete transaction; gdly = cycles before gnt, rdly = WAIT cycles before rvalid.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input int gdly, input int rdly,
                         input logic [31:0] rdata);
    logic        is_nop, is_st, trap, memop;
    int          nb, aoff, off, exp_t;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd, exp_res;
    logic [63:0] v;
    logic        exp_err;
    logic [4:0]  exp_rd;
    logic        exp_req;
    is_nop = (op == 4'hF);
    is_st  = op[3] && !is_nop;
    nb     = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    aoff   = int'(addr[1:0]);
`ifdef LSU_MISALIGNED_TRAP_EN
    trap   = !is_nop && ((aoff % nb) != 0);
`else
    trap   = 1'b0;
`endif
    off      = aoff - (aoff % nb);
    memop    = !is_nop && !trap;
    exp_strb = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    v = ({32'd0, rdata} >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
    if (!op[2] && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    exp_res = v[31:0];
    exp_err = 1'b0;
    exp_rd  = is_st ? 5'd0 : rd;
    if (!memop) begin
      exp_t = 0;
      exp_res = 32'd0;
    end else if (is_st) begin
      exp_t = gdly + 1;
      exp_res = 32'd0;
    end else if (rdly < MW) begin
      exp_t = gdly + 2 + rdly;
    end else begin
      exp_t = gdly + 1 + MW;
      exp_res = 32'd0;
      exp_err = 1'b1;
    end

    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL in_ready_before: got %b want 1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_addr = $urandom; in_wdata = $urandom;
    in_rd = 5'($urandom);
    for (int t = 0; t <= exp_t + 1; t++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== (t == exp_t)) begin
        errs++; $display("FAIL out_valid t=%0d: got %b want %b", t, out_valid, t == exp_t);
      end
      if (t < exp_t || t == exp_t + 1) begin
        vecs++;
        if (out_res !== prev_res) begin
          errs++; $display("FAIL out_res_hold t=%0d: got %h want %h", t, out_res, prev_res);
        end
      end
      exp_req = memop && (t <= gdly);
      vecs++;
      if (mem_req !== exp_req) begin
        errs++; $display("FAIL mem_req t=%0d: got %b want %b", t, mem_req, exp_req);
      end
      if (exp_req) begin
        vecs++;
        if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== is_st || mem_wstrb !== exp_strb ||
            (is_st && mem_wdata !== exp_wd)) begin
          errs++;
          $display("FAIL mem_bus t=%0d: got a=%h we=%b s=%b d=%h want a=%h we=%b s=%b d=%h", t,
                   mem_addr, mem_we, mem_wstrb, mem_wdata, {addr[31:2], 2'b00}, is_st,
                   exp_strb, exp_wd);
        end
      end
      if (t == exp_t) begin
        vecs++;
        if (out_rd !== exp_rd || out_res !== exp_res || out_err !== exp_err ||
            out_mis !== trap) begin
          errs++;
          $display("FAIL resp op=%h a=%h: got rd=%0d res=%h err=%b mis=%b want rd=%0d res=%h err=%b mis=%b",
                   op, addr, out_rd, out_res, out_err, out_mis, exp_rd, exp_res, exp_err, trap);
        end
        prev_res = exp_res;
      end
      if (t == exp_t + 1) begin
        vecs++;
        if (in_ready !== 1'b1) begin
          errs++; $display("FAIL in_ready_after: got %b want 1", in_ready);
        end
      end
      // Next-edge memory inputs; noise where the unit must ignore them.
      mem_gnt   = (memop && t < gdly) ? 1'b0 : (memop && t == gdly) ? 1'b1 : 1'($urandom);
      mem_rdata = $urandom;
      if (memop && !is_st && t > gdly) begin
        mem_rvalid = (t == gdly + 1 + rdly);
        if (mem_rvalid) mem_rdata = rdata;
      end else begin
        mem_rvalid = 1'($urandom);
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_op = 4'h2; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'd0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || out_valid !== 1'b0 || out_rd !== 5'd0 ||
        out_res !== 32'd0 || out_err !== 1'b0 || out_mis !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: got rdy=%b req=%b we=%b s=%b a=%h d=%h v=%b rd=%0d res=%h e=%b m=%b want 1,0s",
               in_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, out_valid, out_rd,
               out_res, out_err, out_mis);
    end
    in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; rst = 1'b0;
    prev_res = 32'd0;
  endtask

  task automatic test_sw();
    run_txn(4'b1010, 32'h100, 32'hDEADBEEF, 5'd5, 0, 0, 32'd0);
  endtask

  task automatic test_lb_lbu();
    run_txn(4'b0000, 32'h103, 32'd0, 5'd7, 0, 0, 32'h80FFFFFF);
    vecs++;
    if (prev_res !== 32'hFFFFFF80) begin
      errs++; $display("FAIL lb_model: got %h want ffffff80", prev_res);
    end
    run_txn(4'b0100, 32'h103, 32'd0, 5'd7, 0, 0, 32'h80FFFFFF);
  endtask

  task automatic test_sh_delayed_gnt();
    run_txn(4'b1001, 32'h102, 32'h1234, 5'd3, 3, 0, 32'd0);
  endtask

  task automatic test_lw_timeout();
    run_txn(4'b0010, 32'h200, 32'd0, 5'd9, 0, 100, 32'd0);
    run_txn(4'b0010, 32'h204, 32'd0, 5'd9, 1, MW - 1, 32'hCAFEF00D);
  endtask

  task automatic test_misaligned();
    run_txn(4'b0001, 32'h101, 32'd0, 5'd4, 1, 0, 32'hABCD8765);
    run_txn(4'b1010, 32'h102, 32'h55AA55AA, 5'd4, 0, 0, 32'd0);
    run_txn(4'b0111, 32'h303, 32'd0, 5'd4, 0, 1, 32'h11223344);
  endtask

  task automatic test_nop();
    run_txn(4'hF, 32'h44, 32'h1, 5'd12, 0, 0, 32'd0);
  endtask

  task automatic test_mid_reset();
    run_txn(4'b0000, 32'h10, 32'd0, 5'd1, 0, 0, 32'h000000A5);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0010; in_addr = 32'h400; in_rd = 5'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev_res = 32'd0;
    vecs++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
      errs++; $display("FAIL mid_reset_idle: got rdy=%b req=%b want 1 0", in_ready, mem_req);
    end
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== 32'd0) begin
        errs++;
        $display("FAIL late_rvalid i=%0d: got v=%b rdy=%b res=%h want 0 1 0", i, out_valid,
                 in_ready, out_res);
      end
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom);
      run_txn(op, $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, MW + 1)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb_lbu();
    test_sh_delayed_gnt();
    test_lw_timeout();
    test_misaligned();
    test_nop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule
